// File: rtl/hs_rx_buffer.sv
// rtl/hs_rx_buffer.sv - four-phase SEND/ACK receiver feeding a first-word-fall-through FIFO
module hs_rx_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk_rx,
    input  logic                           rst_rx,
    input  logic                           SEND_rx,
    input  logic [DATA_WIDTH-1:0]          inputData_rx,
    output logic                           outACK_rx,
    output logic [DATA_WIDTH-1:0]          outDATA_rx,
    output logic                           outVALID_rx,
    input  logic                           READY_rx,
    output logic [$clog2(DEPTH+1)-1:0]     count_rx
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_ACK_HIGH
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic w_send_s;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_send_s = r_sync[SYNC_STAGES-1];
    assign w_full   = (r_count == CNT_FULL);
    assign w_pop    = (r_count != '0) && READY_rx;

    always_ff @(posedge clk_rx or negedge rst_rx) begin
        if (!rst_rx) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], SEND_rx};
        end
    end

    always_ff @(posedge clk_rx or negedge rst_rx) begin
        if (!rst_rx) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Full check uses the pre-edge count, so a same-cycle pop never unblocks a push.
    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_send_s && !w_full) begin
                    w_push       = 1'b1;
                    w_next_state = S_ACK_HIGH;
                end
            end
            S_ACK_HIGH: begin
                if (!w_send_s) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_rx or negedge rst_rx) begin
        if (!rst_rx) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_rx) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= inputData_rx;
        end
    end

    // Storage is never reset; gating with valid keeps the empty-FIFO output at zero.
    assign outDATA_rx  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign outVALID_rx = (r_count != '0);
    assign outACK_rx   = (r_state == S_ACK_HIGH);
    assign count_rx    = r_count;

endmodule
